stage_ctrl_burst: RTL

Parametrised multicycle stage controller for the processor datapath.
- Sequences IF → EXST → MEM, generating the register write enables.
- Adds three capabilities: ready handshakes on instruction and data memory, multi-transfer (burst) memory instructions with a configurable count width, and a halt state.
- Sits between the decoder and the datapath write-enable fan-out.
- Its enable outputs are a drop-in superset of the existing enable set.

---
 rtl/stage_pkg.sv | 23 ++
 rtl/stage_ctrl_burst_if.sv | 32 +++
 rtl/stage_xfer_cnt.sv | 46 ++++
 rtl/stage_ctrl_burst.sv | 130 +++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// Shared definitions for the multicycle stage controller: stage encodings
// and the effective burst-count rule used when a memory instruction starts.
package stage_pkg;

   localparam int CNT_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IF   = 2'b00,
      ST_EXST = 2'b01,
      ST_MEM  = 2'b10,
      ST_HALT = 2'b11
   } stage_e;

   // A requested count of zero still performs one transfer.
   function automatic logic [31:0] eff_xfer_count(input logic [31:0] cnt);
      if (cnt == 32'd0) begin
         return 32'd1;
      end else begin
         return cnt;
      end
   endfunction

endpackage

// File: rtl/stage_ctrl_burst_if.sv
// Handshake and enable bundle between the stage controller (master) and the
// decoder/memory/datapath side (slave).
interface stage_ctrl_burst_if #(
   parameter int CNT_W = 4
);
   logic             imem_ready;
   logic             dmem_ready;
   logic             mem_inst;
   logic [CNT_W-1:0] xfer_cnt;
   logic             halt;
   logic             EXSTtoMEM_Wen;
   logic             IR_Wen;
   logic             PC_Wen;
   logic             PSR_Wen;
   logic             RF_Wen;
   logic             ST_Wen;
   logic [CNT_W-1:0] xfer_idx;
   logic [1:0]       stage;
   logic             halted;

   modport master (
      input  imem_ready, dmem_ready, mem_inst, xfer_cnt, halt,
      output EXSTtoMEM_Wen, IR_Wen, PC_Wen, PSR_Wen, RF_Wen, ST_Wen,
      output xfer_idx, stage, halted
   );

   modport slave (
      output imem_ready, dmem_ready, mem_inst, xfer_cnt, halt,
      input  EXSTtoMEM_Wen, IR_Wen, PC_Wen, PSR_Wen, RF_Wen, ST_Wen,
      input  xfer_idx, stage, halted
   );
endinterface

// File: rtl/stage_xfer_cnt.sv
// Burst transfer counter: loads the transfer count on start, advances the
// index on each completed transfer and flags the final transfer. The index
// stops at n-1 and holds there until the next start.
module stage_xfer_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] n_i,
   input  logic             adv_i,
   output logic [CNT_W-1:0] idx_o,
   output logic             last_o
);
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] idx_q, idx_d;

   assign idx_o  = idx_q;
   assign last_o = (idx_q == (n_q - CNT_W'(1)));

   // Next count/index: start reloads, an advance on a non-final transfer increments.
   always_comb begin
      n_d   = n_q;
      idx_d = idx_q;
      if (start_i) begin
         n_d   = n_i;
         idx_d = {CNT_W{1'b0}};
      end else if (adv_i && !last_o) begin
         idx_d = idx_q + CNT_W'(1);
      end else begin
         idx_d = idx_q;
      end
   end

   // Count and index registers with synchronous reset to a one-transfer burst.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         n_q   <= CNT_W'(1);
         idx_q <= {CNT_W{1'b0}};
      end else begin
         n_q   <= n_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/stage_ctrl_burst.sv
// Multicycle stage controller: sequences IF -> EXST -> MEM (with bursts and
// memory ready handshakes) plus a HALT state, and decodes the register write
// enables from the current stage and inputs.
module stage_ctrl_burst
   import stage_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   stage_ctrl_burst_if.master bus
);
   stage_e           state_q;
   logic             cnt_start;
   logic             cnt_adv;
   logic             cnt_last;
   logic [CNT_W-1:0] cnt_idx;
   logic [CNT_W-1:0] cnt_n;
   logic             e2m_en, ir_en, pc_en, psr_en, rf_en, st_en;

   assign cnt_start = (state_q == ST_EXST) && bus.mem_inst;
   assign cnt_adv   = (state_q == ST_MEM) && bus.dmem_ready;
   assign cnt_n     = CNT_W'(eff_xfer_count(32'(bus.xfer_cnt)));

   stage_xfer_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
      .clk_i   (clk),
      .reset_i (reset),
      .start_i (cnt_start),
      .n_i     (cnt_n),
      .adv_i   (cnt_adv),
      .idx_o   (cnt_idx),
      .last_o  (cnt_last)
   );

   // Stage sequencing; halt is only honoured in IF and HALT so an instruction in flight completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IF;
      end else begin
         case (state_q)
            ST_IF: begin
               if (bus.halt) begin
                  state_q <= ST_HALT;
               end else if (bus.imem_ready) begin
                  state_q <= ST_EXST;
               end else begin
                  state_q <= ST_IF;
               end
            end
            ST_EXST: begin
               if (bus.mem_inst) begin
                  state_q <= ST_MEM;
               end else begin
                  state_q <= ST_IF;
               end
            end
            ST_MEM: begin
               if (bus.dmem_ready && cnt_last) begin
                  state_q <= ST_IF;
               end else begin
                  state_q <= ST_MEM;
               end
            end
            ST_HALT: begin
               if (bus.halt) begin
                  state_q <= ST_HALT;
               end else begin
                  state_q <= ST_IF;
               end
            end
            default: state_q <= ST_IF;
         endcase
      end
   end

   // Enable decode; everything is suppressed while reset is held.
   always_comb begin
      e2m_en = 1'b0;
      ir_en  = 1'b0;
      pc_en  = 1'b0;
      psr_en = 1'b0;
      rf_en  = 1'b0;
      st_en  = 1'b0;
      if (reset) begin
         e2m_en = 1'b0;
      end else begin
         case (state_q)
            ST_IF: begin
               ir_en = !bus.halt && bus.imem_ready;
            end
            ST_EXST: begin
               if (bus.mem_inst) begin
                  e2m_en = 1'b1;
               end else begin
                  pc_en  = 1'b1;
                  psr_en = 1'b1;
                  rf_en  = 1'b1;
                  st_en  = 1'b1;
               end
            end
            ST_MEM: begin
               if (bus.dmem_ready) begin
                  rf_en = 1'b1;
                  st_en = 1'b1;
                  pc_en = cnt_last;
               end else begin
                  rf_en = 1'b0;
               end
            end
            ST_HALT: begin
               ir_en = 1'b0;
            end
            default: begin
               ir_en = 1'b0;
            end
         endcase
      end
   end

   assign bus.EXSTtoMEM_Wen = e2m_en;
   assign bus.IR_Wen        = ir_en;
   assign bus.PC_Wen        = pc_en;
   assign bus.PSR_Wen       = psr_en;
   assign bus.RF_Wen        = rf_en;
   assign bus.ST_Wen        = st_en;
   assign bus.xfer_idx      = cnt_idx;
   assign bus.stage         = state_q;
   assign bus.halted        = (state_q == ST_HALT);

endmodule
